// File: rtl/epochtv1_pkg.sv
// Shared types for the EPOCH TV-1 CPU-side bus initiator: cycle states, queued
// request layout and the VDC address map.
package epochtv1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } bus_state_t;

  typedef struct packed {
    logic        we;
    logic [12:0] a;
    logic [7:0]  d;
  } bus_req_t;

  typedef enum logic [12:0] {
    VRAM_BASE = 13'h0000,
    BGM_BASE  = 13'h1000,
    OAM_BASE  = 13'h1200,
    REG_BASE  = 13'h1400
  } addr_base_t;

endpackage

// File: rtl/epochtv1_req_fifo.sv
// Synchronous request queue with registered count; full/empty derive from the
// count so the ready path never sees request-side inputs.
module epochtv1_req_fifo
  import epochtv1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  bus_req_t               wdata,
  output bus_req_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  bus_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: the storage array is deliberately left out of reset; pointers and
  // count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/epochtv1_bus_master.sv
// EPOCH TV-1 CPU-bus initiator: queues read/write requests and replays each as
// a CE-timed setup/strobe/hold/recover cycle with fully registered bus pins.
module epochtv1_bus_master
  import epochtv1_pkg::*;
#(
  parameter int SETUP_CE   = 1,
  parameter int STROBE_CE  = 2,
  parameter int HOLD_CE    = 1,
  parameter int RECOVER_CE = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [12:0] REQ_A,
  input  logic [7:0]  REQ_D,
  output logic        RSP_VALID,
  output logic        RSP_WE,
  output logic [7:0]  RSP_D,
  output logic        BUSY,
  output logic [12:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  output logic        RDB,
  output logic        WRB,
  output logic        CSB
);

  localparam logic [3:0] SETUP_N   = 4'(SETUP_CE);
  localparam logic [3:0] STROBE_N  = 4'(STROBE_CE);
  localparam logic [3:0] HOLD_N    = 4'(HOLD_CE);
  localparam logic [3:0] RECOVER_N = 4'(RECOVER_CE);

  bus_state_t                      state;
  logic [3:0]                      cnt;
  logic                            cyc_we;
  bus_req_t                        head;
  bus_req_t                        req;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;
  logic                            last_tick;
  logic                            pop;

  assign req       = '{we: REQ_WE, a: REQ_A, d: REQ_D};
  assign last_tick = CE && (cnt == 4'd1);
  // Pop from IDLE, or on the final RECOVER tick so cycles run back-to-back.
  assign pop       = CE && !fifo_empty &&
                     ((state == ST_IDLE) || (state == ST_RECOVER && cnt == 4'd1));
  assign REQ_READY = !fifo_full;
  assign BUSY      = (fifo_count != '0) || (state != ST_IDLE);

  epochtv1_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (REQ_VALID && REQ_READY),
    .pop   (pop),
    .wdata (req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cyc_we    <= 1'b0;
      A         <= '0;
      DB_O      <= '0;
      DB_OE     <= 1'b0;
      RDB       <= 1'b1;
      WRB       <= 1'b1;
      CSB       <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_WE    <= 1'b0;
      RSP_D     <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      if (pop) begin
        state  <= ST_SETUP;
        cnt    <= SETUP_N;
        cyc_we <= head.we;
        A      <= head.a;
        CSB    <= 1'b0;
        DB_OE  <= head.we;
        DB_O   <= head.we ? head.d : 8'h00;
      end else if (CE) begin
        case (state)
          ST_SETUP: begin
            if (last_tick) begin
              state <= ST_STROBE;
              cnt   <= STROBE_N;
              RDB   <= cyc_we;
              WRB   <= !cyc_we;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_STROBE: begin
            if (last_tick) begin
              RDB       <= 1'b1;
              WRB       <= 1'b1;
              RSP_VALID <= 1'b1;
              RSP_WE    <= cyc_we;
              if (!cyc_we) RSP_D <= DB_I;
              if (HOLD_CE == 0) begin
                state <= ST_RECOVER;
                cnt   <= RECOVER_N;
                CSB   <= 1'b1;
                DB_OE <= 1'b0;
              end else begin
                state <= ST_HOLD;
                cnt   <= HOLD_N;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_HOLD: begin
            if (last_tick) begin
              state <= ST_RECOVER;
              cnt   <= RECOVER_N;
              CSB   <= 1'b1;
              DB_OE <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_RECOVER: begin
            if (last_tick) state <= ST_IDLE;
            else           cnt   <= cnt - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
